// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage feeding the IF/ID register.
// Owns the PC, issues word fetches over a req/ack handshake, and holds the
// fetched instruction in a registered output backed by a one-entry skid slot.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   ex2if_jump_en_i/_addr_i          redirect from execute (highest priority)
//   cu2if_stall_i                    downstream not accepting; output holds
//   if2rom_req_o/_addr_o             fetch request (from registered state only)
//   rom2if_ack_i/_data_i             fetch completion and instruction word
//   if2ifid_ins_o/_addr_o/_valid_o   registered instruction out
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex2if_jump_en_i,
  input  logic [31:0] ex2if_jump_addr_i,
  input  logic        cu2if_stall_i,
  output logic        if2rom_req_o,
  output logic [31:0] if2rom_addr_o,
  input  logic        rom2if_ack_i,
  input  logic [31:0] rom2if_data_i,
  output logic [31:0] if2ifid_ins_o,
  output logic [31:0] if2ifid_addr_o,
  output logic        if2ifid_valid_o
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        started_q, started_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] out_ins_q, out_ins_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] skid_ins_q, skid_ins_d;
  logic [31:0] skid_addr_q, skid_addr_d;
  logic        skid_vld_q, skid_vld_d;

  logic        ack_ok;
  logic        consume;
  logic [31:0] jump_tgt;

  // started_q keeps req low during the reset cycle and the cycle it is released,
  // so the first request appears the cycle after rst_n is sampled high.
  assign if2rom_req_o  = started_q & (state_q != ST_FULL);
  // While a killed request drains, the bus address must stay at the old PC even
  // though pc_q has already moved to the redirect target.
  assign if2rom_addr_o = kill_q ? drain_addr_q : pc_q;

  assign if2ifid_ins_o   = out_ins_q;
  assign if2ifid_addr_o  = out_addr_q;
  assign if2ifid_valid_o = out_vld_q;

  assign ack_ok   = rom2if_ack_i & if2rom_req_o;
  assign consume  = out_vld_q & ~cu2if_stall_i;
  assign jump_tgt = ex2if_jump_addr_i & 32'hFFFF_FFFC;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    started_d    = 1'b1;
    drain_addr_d = drain_addr_q;
    out_ins_d    = out_ins_q;
    out_addr_d   = out_addr_q;
    out_vld_d    = out_vld_q;
    skid_ins_d   = skid_ins_q;
    skid_addr_d  = skid_addr_q;
    skid_vld_d   = skid_vld_q;

    if (ex2if_jump_en_i) begin
      out_vld_d  = 1'b0;
      out_ins_d  = NOP_INS;
      skid_vld_d = 1'b0;
      skid_ins_d = NOP_INS;
      pc_d       = jump_tgt;
      case (state_q)
        ST_FETCH: begin
          if (if2rom_req_o && !ack_ok) begin
            state_d      = ST_DRAIN;
            kill_d       = 1'b1;
            drain_addr_d = pc_q;
          end
        end
        ST_DRAIN: begin
          if (ack_ok) begin
            state_d = ST_FETCH;
            kill_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_FETCH;
          kill_d  = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (ack_ok) begin
            pc_d = pc_q + 32'd4;
            if (!out_vld_q || consume) begin
              out_ins_d  = rom2if_data_i;
              out_addr_d = pc_q;
              out_vld_d  = 1'b1;
            end else begin
              // Output is stalled: park the word and stop fetching.
              skid_ins_d  = rom2if_data_i;
              skid_addr_d = pc_q;
              skid_vld_d  = 1'b1;
              state_d     = ST_FULL;
            end
          end else if (consume) begin
            out_vld_d = 1'b0;
            out_ins_d = NOP_INS;
          end
        end
        ST_FULL: begin
          if (consume) begin
            out_ins_d  = skid_ins_q;
            out_addr_d = skid_addr_q;
            out_vld_d  = skid_vld_q;
            skid_vld_d = 1'b0;
            skid_ins_d = NOP_INS;
            state_d    = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (consume) begin
            out_vld_d = 1'b0;
            out_ins_d = NOP_INS;
          end
          if (ack_ok) begin
            state_d = ST_FETCH;
            kill_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_FETCH;
          kill_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      started_q    <= 1'b0;
      drain_addr_q <= RESET_PC;
      out_ins_q    <= NOP_INS;
      out_addr_q   <= RESET_PC;
      out_vld_q    <= 1'b0;
      skid_ins_q   <= NOP_INS;
      skid_addr_q  <= RESET_PC;
      skid_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      started_q    <= started_d;
      drain_addr_q <= drain_addr_d;
      out_ins_q    <= out_ins_d;
      out_addr_q   <= out_addr_d;
      out_vld_q    <= out_vld_d;
      skid_ins_q   <= skid_ins_d;
      skid_addr_q  <= skid_addr_d;
      skid_vld_q   <= skid_vld_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized stall/jump traffic,
// with a program-order scoreboard and a bus-hold monitor running throughout.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INS  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        stall = 1'b0;
  logic        req;
  logic [31:0] raddr;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [31:0] ins;
  logic [31:0] oaddr;
  logic        valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INS(NOP_INS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex2if_jump_en_i(jump_en), .ex2if_jump_addr_i(jump_addr),
    .cu2if_stall_i(stall),
    .if2rom_req_o(req), .if2rom_addr_o(raddr),
    .rom2if_ack_i(ack), .rom2if_data_i(rdata),
    .if2ifid_ins_o(ins), .if2ifid_addr_o(oaddr), .if2ifid_valid_o(valid)
  );

  // ROM model: word content = addr ^ rom_key, ack after rom_lat wait cycles.
  int          rom_lat = 0;
  int          rom_cnt = 0;
  logic [31:0] rom_key = 32'h0;

  always @(posedge clk) begin
    #1;
    if (req === 1'b1) begin
      if (rom_cnt >= rom_lat) begin
        ack     = 1'b1;
        rdata   = raddr ^ rom_key;
        rom_cnt = 0;
      end else begin
        ack     = 1'b0;
        rdata   = 32'hDEAD_BEEF;
        rom_cnt = rom_cnt + 1;
      end
    end else begin
      ack     = 1'b0;
      rom_cnt = 0;
    end
  end

  // Scoreboard: consumed instructions must follow program order from RESET_PC,
  // restarting at the aligned target after every jump; plus bus-hold rule.
  logic [31:0] exp_addr = RESET_PC;
  int          consumed = 0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  always @(negedge clk) begin
    #3;
    if (rst_n !== 1'b1) begin
      exp_addr  = RESET_PC;
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        checks++;
        if (req !== 1'b1 || raddr !== prev_addr) begin
          errors++;
          $display("FAIL bus_hold: req=%b addr=%h, required req=1 addr=%h", req, raddr, prev_addr);
        end
      end
      if (valid === 1'b1 && stall === 1'b0) begin
        checks++;
        if (oaddr !== exp_addr || ins !== (exp_addr ^ rom_key)) begin
          errors++;
          $display("FAIL order: addr=%h ins=%h, required addr=%h ins=%h",
                   oaddr, ins, exp_addr, exp_addr ^ rom_key);
        end
        exp_addr = exp_addr + 32'd4;
        consumed++;
      end
      if (valid !== 1'b1) begin
        checks++;
        if (ins !== NOP_INS) begin
          errors++;
          $display("FAIL invalid_nop: ins=%h, required %h", ins, NOP_INS);
        end
      end
      if (jump_en === 1'b1) exp_addr = jump_addr & 32'hFFFF_FFFC;
      prev_pend = (req === 1'b1) && (ack !== 1'b1);
      prev_addr = raddr;
    end
  end

  // Advance to the sampling point of the next cycle (mid low phase).
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset(input int lat, input logic [31:0] key);
    rst_n   = 1'b0;
    stall   = 1'b0;
    jump_en = 1'b0;
    step();
    rom_lat = lat;
    rom_key = key;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; jump_en = 1'b0; rom_lat = 0; rom_key = 32'h0;
    step(); step();
    checks++;
    if (req !== 1'b0 || valid !== 1'b0 || ins !== NOP_INS || oaddr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b ins=%h addr=%h, required 0 0 %h %h",
               req, valid, ins, oaddr, NOP_INS, RESET_PC);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (req !== 1'b1 || raddr !== RESET_PC || valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h valid=%b, required 1 %h 0", req, raddr, valid, RESET_PC);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || oaddr !== 32'(4 * i) || ins !== 32'(4 * i) ||
          req !== 1'b1 || raddr !== 32'(4 * i + 4)) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b addr=%h ins=%h req=%b raddr=%h, required 1 %h %h 1 %h",
                 i, valid, oaddr, ins, req, raddr, 4 * i, 4 * i, 4 * i + 4);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (valid !== 1'b1 || oaddr !== 32'h8 || req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b addr=%h req=%b, required 1 00000008 0", k, valid, oaddr, req);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (valid !== 1'b1 || oaddr !== 32'hC || ins !== 32'hC || req !== 1'b1 || raddr !== 32'h10) begin
      errors++;
      $display("FAIL stall_release: valid=%b addr=%h ins=%h req=%b raddr=%h, required 1 c c 1 10",
               valid, oaddr, ins, req, raddr);
    end
    step();
    checks++;
    if (valid !== 1'b1 || oaddr !== 32'h10) begin
      errors++;
      $display("FAIL stall_next: valid=%b addr=%h, required 1 00000010", valid, oaddr);
    end
  endtask

  task automatic test_jump();
    jump_en = 1'b1; jump_addr = 32'h0000_0103;
    step();
    jump_en = 1'b0;
    checks++;
    if (valid !== 1'b0 || ins !== NOP_INS || req !== 1'b1 || raddr !== 32'h100) begin
      errors++;
      $display("FAIL jump_bubble: valid=%b ins=%h req=%b raddr=%h, required 0 %h 1 00000100",
               valid, ins, req, raddr, NOP_INS);
    end
    step();
    checks++;
    if (valid !== 1'b1 || oaddr !== 32'h100 || ins !== 32'h100) begin
      errors++;
      $display("FAIL jump_target: valid=%b addr=%h ins=%h, required 1 00000100 00000100", valid, oaddr, ins);
    end
  endtask

  task automatic test_wrap();
    jump_en = 1'b1; jump_addr = 32'hFFFF_FFF8;
    step();
    jump_en = 1'b0;
    step();
    step();
    checks++;
    if (valid !== 1'b1 || oaddr !== 32'hFFFF_FFFC || req !== 1'b1 || raddr !== 32'h0) begin
      errors++;
      $display("FAIL wrap: valid=%b addr=%h req=%b raddr=%h, required 1 fffffffc 1 00000000",
               valid, oaddr, req, raddr);
    end
    step();
    checks++;
    if (valid !== 1'b1 || oaddr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_out: valid=%b addr=%h, required 1 00000000", valid, oaddr);
    end
  endtask

  task automatic test_drain();
    bit found = 0;
    int hold = 0;
    bit done = 0;
    do_reset(3, 32'h0);
    for (int i = 0; i < 20 && !found; i++) begin
      if (req === 1'b1 && raddr === 32'h4) found = 1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL drain_setup: req for 00000004 never seen, raddr=%h", raddr);
    end
    jump_en = 1'b1; jump_addr = 32'h0000_0200;
    step();
    jump_en = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (req === 1'b1 && raddr === 32'h4) begin
        hold++;
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL drain_valid: valid=%b, required 0", valid);
        end
        step();
      end else done = 1;
    end
    checks++;
    if (hold != 3 || req !== 1'b1 || raddr !== 32'h200) begin
      errors++;
      $display("FAIL drain: hold=%0d req=%b raddr=%h, required hold=3 req=1 raddr=00000200", hold, req, raddr);
    end
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (valid === 1'b1) done = 1;
      else step();
    end
    checks++;
    if (valid !== 1'b1 || oaddr !== 32'h200 || ins !== 32'h200) begin
      errors++;
      $display("FAIL drain_target: valid=%b addr=%h ins=%h, required 1 00000200 00000200", valid, oaddr, ins);
    end
  endtask

  task automatic test_reset_full();
    do_reset(0, 32'h0);
    step(); step();
    stall = 1'b1;
    step(); step();
    checks++;
    if (req !== 1'b0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL full_setup: req=%b valid=%b, required 0 1", req, valid);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (valid !== 1'b0 || ins !== NOP_INS || req !== 1'b0 || oaddr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_full: valid=%b ins=%h req=%b addr=%h, required 0 %h 0 %h",
               valid, ins, req, oaddr, NOP_INS, RESET_PC);
    end
    rst_n = 1'b1;
    stall = 1'b0;
    step();
    checks++;
    if (req !== 1'b1 || raddr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_full_req: req=%b raddr=%h, required 1 %h", req, raddr, RESET_PC);
    end
  endtask

  task automatic test_random();
    for (int lat = 0; lat < 3; lat++) begin
      int base;
      do_reset(lat, $urandom);
      base = consumed;
      for (int i = 0; i < 250; i++) begin
        step();
        stall     = ($urandom_range(0, 9) < 3);
        jump_en   = ($urandom_range(0, 19) == 0);
        jump_addr = $urandom;
      end
      step();
      stall = 1'b0;
      jump_en = 1'b0;
      checks++;
      if (consumed - base < 20) begin
        errors++;
        $display("FAIL random_progress[lat=%0d]: consumed=%0d, required >= 20", lat, consumed - base);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_wrap();
    test_drain();
    test_reset_full();
    test_random();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
